// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - handshaked multi-cycle phase sequencer and PC owner for the RV32I core
//
// Purpose: walks each instruction through FETCH, DECODE, READ, EXEC, MEM, WB
// and PCUPD. It stalls on imem_ready/dmem_ready, stops on traps or halt
// requests, and counts retired instructions.
//
// Ports:
//   CLK100MHZ, rst     clock and synchronous active-high reset
//   start              leave IDLE; clears halted/trap_cause/pending halt
//   halt_req           stop at the next instruction boundary
//   imem_ready         instruction word valid (sampled in FETCH only)
//   dmem_ready         load/store done (sampled in MEM only)
//   is_load, is_store  decoded memory-op flags
//   rd_en, rd          decoded destination write enable and index
//   illegal, is_ebreak decoded trap flags
//   taken_branch       branch/jump taken
//   target             branch/jump target
//   state              current phase (0 IDLE .. 7 PCUPD)
//   pc                 address of the instruction in flight
//   fetch_req          high throughout FETCH
//   mem_req            high throughout MEM for loads/stores
//   rf_we              register-file write strobe in WB (never for x0)
//   retire             one-cycle pulse in PCUPD on successful completion
//   halted, trap_cause stop flag and reason (0 halt, 1 illegal, 2 misaligned, 3 ebreak)
//   instret            retired-instruction counter (wraps)

module cpu_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          INSTRET_W = 32
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 rd_en,
  input  logic [4:0]           rd,
  input  logic                 illegal,
  input  logic                 is_ebreak,
  input  logic                 taken_branch,
  input  logic [31:0]          target,
  output logic [2:0]           state,
  output logic [31:0]          pc,
  output logic                 fetch_req,
  output logic                 mem_req,
  output logic                 rf_we,
  output logic                 retire,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_PCUPD  = 3'd7
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic                   halted_q, halted_d;
  logic [1:0]             trap_q, trap_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   pend_q, pend_d;
  // Misaligned-target flag captured in WB. The branch unit output is stable
  // from EXEC on, so latching it one phase early lets retire be a pure decode
  // of registered state instead of a path from the branch unit inputs.
  logic                   misal_q, misal_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    instret_d = instret_q;
    pend_d    = pend_q;
    misal_d   = misal_q;

    if (state_q != S_IDLE && halt_req) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          halted_d = 1'b0;
          trap_d   = 2'd0;
          pend_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (illegal) begin
          state_d  = S_IDLE;
          halted_d = 1'b1;
          trap_d   = 2'd1;
          pend_d   = 1'b0;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_MEM;
      S_MEM: begin
        // Non-memory ops pass through MEM in one cycle.
        if (!(is_load || is_store) || dmem_ready) state_d = S_WB;
      end
      S_WB: begin
        misal_d = taken_branch && (target[1:0] != 2'b00);
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        if (misal_q) begin
          state_d  = S_IDLE;
          halted_d = 1'b1;
          trap_d   = 2'd2;
          pend_d   = 1'b0;
        end else if (is_ebreak) begin
          instret_d = instret_q + INSTRET_W'(1);
          state_d   = S_IDLE;
          halted_d  = 1'b1;
          trap_d    = 2'd3;
          pend_d    = 1'b0;
        end else begin
          pc_d      = taken_branch ? target : pc_q + 32'd4;
          instret_d = instret_q + INSTRET_W'(1);
          if (pend_q || halt_req) begin
            state_d  = S_IDLE;
            halted_d = 1'b1;
            trap_d   = 2'd0;
            pend_d   = 1'b0;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      trap_q    <= 2'd0;
      instret_q <= '0;
      pend_q    <= 1'b0;
      misal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
      pend_q    <= pend_d;
      misal_q   <= misal_d;
    end
  end

  assign state      = state_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign trap_cause = trap_q;
  assign instret    = instret_q;
  assign fetch_req  = (state_q == S_FETCH);
  assign mem_req    = (state_q == S_MEM) && (is_load || is_store);
  assign rf_we      = (state_q == S_WB) && rd_en && (rd != 5'd0);
  assign retire     = (state_q == S_PCUPD) && !misal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer

module tb_cpu_sequencer;

  logic        CLK100MHZ = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic        illegal = 1'b0;
  logic        is_ebreak = 1'b0;
  logic        taken_branch = 1'b0;
  logic [31:0] target = 32'd0;
  logic [2:0]  state;
  logic [31:0] pc;
  logic        fetch_req;
  logic        mem_req;
  logic        rf_we;
  logic        retire;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [3:0]  instret;

  int total = 0;
  int bad = 0;
  int cyc, nmem, nrfwe, nret;

  cpu_sequencer #(.RESET_PC(32'h0), .INSTRET_W(4)) dut (
    .CLK100MHZ(CLK100MHZ), .rst(rst), .start(start), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .is_load(is_load),
    .is_store(is_store), .rd_en(rd_en), .rd(rd), .illegal(illegal),
    .is_ebreak(is_ebreak), .taken_branch(taken_branch), .target(target),
    .state(state), .pc(pc), .fetch_req(fetch_req), .mem_req(mem_req),
    .rf_we(rf_we), .retire(retire), .halted(halted), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // Runs one instruction starting from FETCH; readiness outside its own
  // phase is driven high so that sampling it there would be visible.
  task automatic run_instr(input int iw, input int dw, input bit halt_exec,
                           output int c, output int m, output int w, output int r);
    int fw, mw;
    bit done;
    logic [2:0] prev;
    c = 0; m = 0; w = 0; r = 0; fw = 0; mw = 0; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (state != 3'd0) c++;
      if (mem_req) m++;
      if (rf_we) w++;
      if (retire) r++;
      imem_ready = (state == 3'd1) ? (fw >= iw) : 1'b1;
      if (state == 3'd1) fw++;
      dmem_ready = (state == 3'd5) ? (mw >= dw) : 1'b1;
      if (state == 3'd5) mw++;
      halt_req = halt_exec && (state == 3'd4);
      prev = state;
      step();
      if (prev == 3'd7 || state == 3'd0) done = 1;
    end
    halt_req = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check("run_done", {31'd0, done}, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instret", {28'd0, instret}, 32'd0);
    check("rst_outs", {26'd0, fetch_req, mem_req, rf_we, retire, halted, 1'b0} | {30'd0, trap_cause}, 32'd0);
    step();
    check("idle_hold", {29'd0, state}, 32'd0);

    do_start();
    check("start_fetch", {29'd0, state}, 32'd1);
    check("start_fetch_req", {31'd0, fetch_req}, 32'd1);

    // Four zero-wait ADDIs.
    rd_en = 1'b1; rd = 5'd5;
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
      check("addi_cycles", cyc, 32'd7);
      check("addi_retire", nret, 32'd1);
      check("addi_rfwe", nrfwe, 32'd1);
      check("addi_pc", pc, 32'(4 * (i + 1)));
    end
    check("addi_instret", {28'd0, instret}, 32'd4);

    // Fetch stall 3, load with dmem stall 2.
    is_load = 1'b1;
    run_instr(3, 2, 0, cyc, nmem, nrfwe, nret);
    is_load = 1'b0;
    check("stall_cycles", cyc, 32'd12);
    check("stall_memreq", nmem, 32'd3);
    check("stall_rfwe", nrfwe, 32'd1);
    check("stall_pc", pc, 32'h14);
    check("stall_instret", {28'd0, instret}, 32'd5);

    // Taken branch to 0x40.
    taken_branch = 1'b1; target = 32'h40;
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    taken_branch = 1'b0;
    check("br_pc", pc, 32'h40);
    check("br_memreq", nmem, 32'd0);

    // ADD to x0: retires, no register write.
    rd = 5'd0;
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    check("x0_rfwe", nrfwe, 32'd0);
    check("x0_retire", nret, 32'd1);
    check("x0_pc", pc, 32'h44);
    rd = 5'd3;

    // Halt request during EXEC.
    run_instr(0, 0, 1, cyc, nmem, nrfwe, nret);
    check("halt_retire", nret, 32'd1);
    check("halt_state", {29'd0, state}, 32'd0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_cause", {30'd0, trap_cause}, 32'd0);
    check("halt_pc", pc, 32'h48);
    check("halt_instret", {28'd0, instret}, 32'd8);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    do_start();
    check("resume_state", {29'd0, state}, 32'd1);
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_pc", pc, 32'h48);
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    check("idle_halt_ignored", {29'd0, state}, 32'd1);
    check("resume_pc2", pc, 32'h4c);

    // Illegal instruction trap.
    illegal = 1'b1;
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    illegal = 1'b0;
    check("ill_cycles", cyc, 32'd2);
    check("ill_state", {29'd0, state}, 32'd0);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_cause", {30'd0, trap_cause}, 32'd1);
    check("ill_instret", {28'd0, instret}, 32'd9);
    check("ill_retire", nret, 32'd0);

    // Misaligned jump target.
    do_start();
    check("start_clr_cause", {30'd0, trap_cause}, 32'd0);
    taken_branch = 1'b1; target = 32'h42;
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    taken_branch = 1'b0;
    check("mis_cause", {30'd0, trap_cause}, 32'd2);
    check("mis_pc", pc, 32'h4c);
    check("mis_retire", nret, 32'd0);
    check("mis_instret", {28'd0, instret}, 32'd9);

    // EBREAK.
    do_start();
    is_ebreak = 1'b1;
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    is_ebreak = 1'b0;
    check("ebrk_cause", {30'd0, trap_cause}, 32'd3);
    check("ebrk_halted", {31'd0, halted}, 32'd1);
    check("ebrk_retire", nret, 32'd1);
    check("ebrk_instret", {28'd0, instret}, 32'd10);
    check("ebrk_pc", pc, 32'h4c);

    // Counter wrap (4-bit counter): 10 -> 15 -> 0 -> 1.
    do_start();
    for (int i = 0; i < 5; i++) run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    check("wrap_max", {28'd0, instret}, 32'd15);
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    check("wrap_zero", {28'd0, instret}, 32'd0);
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    check("wrap_one", {28'd0, instret}, 32'd1);
    check("wrap_pc", pc, 32'h68);

    // Reset during a MEM stall, with a halt pending; start in the same cycle.
    is_load = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0; halt_req = 1'b1;
    for (int k = 0; k < 20 && state != 3'd5; k++) begin
      step();
      halt_req = 1'b0;
    end
    halt_req = 1'b0;
    step();
    check("memstall_state", {29'd0, state}, 32'd5);
    check("memstall_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; is_load = 1'b0; imem_ready = 1'b0;
    check("mrst_state", {29'd0, state}, 32'd0);
    check("mrst_pc", pc, 32'h0);
    check("mrst_instret", {28'd0, instret}, 32'd0);
    check("mrst_outs", {26'd0, fetch_req, mem_req, rf_we, retire, halted, 1'b0} | {30'd0, trap_cause}, 32'd0);
    do_start();
    run_instr(0, 0, 0, cyc, nmem, nrfwe, nret);
    check("mrst_pend_clr", {29'd0, state}, 32'd1);
    check("mrst_pc2", pc, 32'h4);
    check("mrst_instret2", {28'd0, instret}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
